buffer_ctrl: RTL and testbench

BUFFER_CTRL -- requirements
Module: buffer_ctrl

---
 rtl/buf_pkg.sv | 24 ++
 rtl/ptr_advance.sv | 30 +++
 rtl/buffer_ctrl.sv | 117 +++++++++++
 tb/tb_buffer_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/buf_pkg.sv
// Shared types, default geometry and width helpers for the buffer controller.
package buf_pkg;

    localparam int unsigned DEF_SIZE = 16;
    localparam int unsigned DEF_K    = 4;
    localparam int unsigned DEF_J    = 8;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_AVAIL = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    function automatic int unsigned addr_w(input int unsigned size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // One extra bit so that a completely full buffer (count == SIZE) is representable.
    function automatic int unsigned cnt_w(input int unsigned size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/ptr_advance.sv
// Registered modulo-SIZE pointer that steps by STEP words when enabled.
module ptr_advance
    import buf_pkg::*;
#(
    parameter int unsigned SIZE = DEF_SIZE,
    parameter int unsigned STEP = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    output logic [addr_w(SIZE)-1:0]   o_ptr
);

    localparam int unsigned AW = addr_w(SIZE);
    // SIZE is a power of two, so natural AW-bit overflow is the modulo wrap.
    localparam logic [AW-1:0] C_STEP = AW'(STEP % SIZE);

    logic [AW-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + C_STEP;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/buffer_ctrl.sv
// Occupancy/pointer controller for a K-in, J-out word buffer.
// Define BUFFER_CTRL_ERR_EN to build the sticky ovf_err/udf_err flags.
module buffer_ctrl
    import buf_pkg::*;
#(
    parameter int unsigned SIZE = DEF_SIZE,
    parameter int unsigned K    = DEF_K,
    parameter int unsigned J    = DEF_J
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic                     ld,
    output logic [addr_w(SIZE)-1:0]  write_add,
    output logic [addr_w(SIZE)-1:0]  read_add,
    output logic [cnt_w(SIZE)-1:0]   count,
    output state_t                   state,
    output logic                     ovf_err,
    output logic                     udf_err
);

    localparam int unsigned CW = cnt_w(SIZE);
    localparam logic [CW-1:0] C_SIZE = CW'(SIZE);
    localparam logic [CW-1:0] C_K    = CW'(K);
    localparam logic [CW-1:0] C_J    = CW'(J);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    state_t        r_state;
    state_t        w_state_next;
    logic          w_pop_ok;

    assign in_ready  = (C_SIZE - r_count) >= C_K;
    assign out_valid = r_count >= C_J;
    assign ld        = push && in_ready && !rst;
    assign w_pop_ok  = pop && out_valid && !rst;

    // Accepted loads keep count <= SIZE-K beforehand, so the sum never overflows CW bits.
    always_comb begin
        w_count_next = r_count;
        if (ld) begin
            w_count_next = w_count_next + C_K;
        end
        if (w_pop_ok) begin
            w_count_next = w_count_next - C_J;
        end
    end

    always_comb begin
        w_state_next = S_PART;
        if (w_count_next == '0) begin
            w_state_next = S_EMPTY;
        end else if ((C_SIZE - w_count_next) < C_K) begin
            w_state_next = S_FULL;
        end else if (w_count_next >= C_J) begin
            w_state_next = S_AVAIL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_state <= S_EMPTY;
        end else begin
            r_count <= w_count_next;
            r_state <= w_state_next;
        end
    end

    ptr_advance #(
        .SIZE (SIZE),
        .STEP (K)
    ) u_wr_ptr (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (ld),
        .o_ptr (write_add)
    );

    ptr_advance #(
        .SIZE (SIZE),
        .STEP (J)
    ) u_rd_ptr (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_pop_ok),
        .o_ptr (read_add)
    );

    assign count = r_count;
    assign state = r_state;

`ifdef BUFFER_CTRL_ERR_EN
    logic r_ovf_err;
    logic r_udf_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            if (push && !in_ready) r_ovf_err <= 1'b1;
            if (pop && !out_valid) r_udf_err <= 1'b1;
        end
    end

    assign ovf_err = r_ovf_err;
    assign udf_err = r_udf_err;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_ctrl.sv
// Scoreboard bench for buffer_ctrl: directed scenarios then randomized traffic vs. a queue model.
module tb_buffer_ctrl;
    import buf_pkg::*;

    localparam int unsigned SIZE = 16;
    localparam int unsigned K    = 4;
    localparam int unsigned J    = 8;
    localparam int unsigned AW   = $clog2(SIZE);
    localparam int unsigned CW   = $clog2(SIZE) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          in_ready, out_valid, ld, ovf_err, udf_err;
    logic [AW-1:0] write_add, read_add;
    logic [CW-1:0] count;
    state_t        state;

    buffer_ctrl #(
        .SIZE (SIZE),
        .K    (K),
        .J    (J)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .ld        (ld),
        .write_add (write_add),
        .read_add  (read_add),
        .count     (count),
        .state     (state),
        .ovf_err   (ovf_err),
        .udf_err   (udf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ld;
        int wa;
        int ra;
        int cnt;
        int st;
        bit rdy;
        bit vld;
        bit ovf;
        bit udf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   err_en;

    // Reference model: occupancy as a plain word count, pointers as modular integers.
    int m_cnt = 0;
    int m_wa  = 0;
    int m_ra  = 0;
    bit m_ovf = 0;
    bit m_udf = 0;

    initial begin
`ifdef BUFFER_CTRL_ERR_EN
        err_en = 1'b1;
`else
        err_en = 1'b0;
`endif
    end

    function automatic int state_of(input int c);
        if (c == 0) return 0;
        if (SIZE - c < K) return 3;
        if (c >= J) return 2;
        return 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit p, input bit q, input bit r);
        exp_t e;
        bit   rdy, vld, acc_p, acc_q;
        @(negedge clk);
        push = p;
        pop  = q;
        rst  = r;
        rdy   = (SIZE - m_cnt) >= K;
        vld   = m_cnt >= J;
        acc_p = p && rdy && !r;
        acc_q = q && vld && !r;
        e.ld  = acc_p;
        if (r) begin
            m_cnt = 0; m_wa = 0; m_ra = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (acc_p) begin
                m_wa  = (m_wa + K) % SIZE;
                m_cnt = m_cnt + K;
            end
            if (acc_q) begin
                m_ra  = (m_ra + J) % SIZE;
                m_cnt = m_cnt - J;
            end
            if (err_en && p && !rdy) m_ovf = 1;
            if (err_en && q && !vld) m_udf = 1;
        end
        e.wa  = m_wa;
        e.ra  = m_ra;
        e.cnt = m_cnt;
        e.st  = state_of(m_cnt);
        e.rdy = (SIZE - m_cnt) >= K;
        e.vld = m_cnt >= J;
        e.ovf = m_ovf;
        e.udf = m_udf;
        sb.push_back(e);
    endtask

    // Monitor: ld is checked just before the edge, registered outputs just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ld", 32'(ld), 32'(e.ld));
                @(posedge clk);
                #1;
                chk("write_add", 32'(write_add), 32'(e.wa));
                chk("read_add", 32'(read_add), 32'(e.ra));
                chk("count", 32'(count), 32'(e.cnt));
                chk("state", 32'(state), 32'(e.st));
                chk("in_ready", 32'(in_ready), 32'(e.rdy));
                chk("out_valid", 32'(out_valid), 32'(e.vld));
                chk("ovf_err", 32'(ovf_err), 32'(e.ovf));
                chk("udf_err", 32'(udf_err), 32'(e.udf));
            end
        end
    end

    initial begin
        int wait_cyc;
        // Reset and idle.
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        // Fill with four pushes, fifth push overflows.
        repeat (4) step(1, 0, 0);
        step(1, 0, 0);
        // Drain with two pops, third pop underflows.
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        // Bring to 8, then simultaneous push and pop.
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        // Pop at count 4 is rejected.
        step(0, 1, 0);
        // Reach 12 then reset while pushing.
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        step(0, 0, 0);
        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        push = 0;
        pop  = 0;
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
